// File: rtl/dlatn_char_driver.sv
// -----------------------------------------------------------------------------
// dlatn_char_driver
//
// Stimulus driver and checker for negative-level latch cells (gp12t3v3).
// Generates the latch clock (LCLK, low = transparent) and latch data (LD).
// LD moves to the expected value SETUP cycles before LCLK rises. It is then
// perturbed HOLD cycles after the rise, which must not disturb the captured
// value. LQ is sampled at the end of every high phase, and the passing and
// failing latch cycles are counted.
//
// Ports
//   CLK       system clock, rising edge
//   RN        asynchronous active-low reset (aborts any run)
//   START     one-cycle run request, honoured only in IDLE
//   HALF      latch-clock half period in CLK cycles (values below 2 act as 2)
//   SETUP     CLK cycles LD is stable before the LCLK rise
//   HOLD      CLK cycles after the LCLK rise at which LD is perturbed
//   NCYC      number of latch cycles per run
//   LQ        Q output of the latch under test
//   LCLK      latch clock
//   LD        latch data
//   BUSY      run in progress
//   DONE      one-cycle pulse at the end of a run
//   PASS_CNT  passing latch cycles (saturating)
//   FAIL_CNT  failing latch cycles (saturating)
// -----------------------------------------------------------------------------
module dlatn_char_driver #(
  parameter int CNT_W = 8,
  parameter int PH_W  = 4
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             START,
  input  logic [PH_W-1:0]  HALF,
  input  logic [PH_W-1:0]  SETUP,
  input  logic [PH_W-1:0]  HOLD,
  input  logic [CNT_W-1:0] NCYC,
  input  logic             LQ,
  output logic             LCLK,
  output logic             LD,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] PASS_CNT,
  output logic [CNT_W-1:0] FAIL_CNT
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_FINISH
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q;
  logic [PH_W-1:0]  c_q;          // phase counter within LOW / HIGH
  logic [PH_W-1:0]  hm1_q;        // H-1, last phase index
  logic [PH_W-1:0]  ld_pos_q;     // LOW phase at which LD takes exp
  logic [PH_W-1:0]  pert_pos_q;   // HIGH phase at which LD is perturbed
  logic [CNT_W-1:0] ncyc_q;
  logic [CNT_W-1:0] cyc_q;        // completed latch cycles
  logic [CNT_W-1:0] pass_q;
  logic [CNT_W-1:0] fail_q;
  logic             exp_q;        // value the latch must capture this cycle
  logic             lclk_q;
  logic             ld_q;
  logic             busy_q;
  logic             done_q;

  // Run parameters derived from the inputs; registered only when a run starts.
  logic [PH_W-1:0]  hm1_d;
  logic [PH_W-1:0]  setup_c;
  logic [PH_W-1:0]  ld_pos_d;
  logic [PH_W-1:0]  pert_pos_d;
  logic [PH_W-1:0]  c_inc;
  logic [CNT_W-1:0] cyc_inc;

  // NOTE: every always_comb output is assigned on every path (no else-less
  // ifs), so no latches are inferred.
  always_comb begin
    hm1_d      = (HALF < PH_W'(2)) ? PH_W'(1) : HALF - PH_W'(1);
    setup_c    = (SETUP < hm1_d) ? SETUP : hm1_d;
    ld_pos_d   = hm1_d - setup_c;
    pert_pos_d = (HOLD < hm1_d) ? HOLD : hm1_d;
    c_inc      = c_q + PH_W'(1);
    cyc_inc    = cyc_q + CNT_W'(1);
  end

  // Outputs are registered from the state being entered, so LCLK/LD changes
  // are visible during the phase cycle they belong to.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q    <= S_IDLE;
      c_q        <= '0;
      hm1_q      <= PH_W'(1);
      ld_pos_q   <= '0;
      pert_pos_q <= '0;
      ncyc_q     <= '0;
      cyc_q      <= '0;
      pass_q     <= '0;
      fail_q     <= '0;
      exp_q      <= 1'b0;
      lclk_q     <= 1'b1;
      ld_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (START) begin
            pass_q     <= '0;
            fail_q     <= '0;
            hm1_q      <= hm1_d;
            ld_pos_q   <= ld_pos_d;
            pert_pos_q <= pert_pos_d;
            ncyc_q     <= NCYC;
            cyc_q      <= '0;
            c_q        <= '0;
            if (NCYC == '0) begin
              state_q <= S_FINISH;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_LOW;
              busy_q  <= 1'b1;
              lclk_q  <= 1'b0;
              exp_q   <= ~ld_q;
              // Setup clamped to H-1: data moves in the very first LOW cycle.
              if (ld_pos_d == '0) ld_q <= ~ld_q;
            end
          end
        end

        S_LOW: begin
          if (c_q == hm1_q) begin
            state_q <= S_HIGH;
            c_q     <= '0;
            lclk_q  <= 1'b1;
            // Zero hold: perturbation coincides with the LCLK rise.
            if (pert_pos_q == '0) ld_q <= ~exp_q;
          end else begin
            c_q <= c_inc;
            if (c_inc == ld_pos_q) ld_q <= exp_q;
          end
        end

        S_HIGH: begin
          if (c_q == hm1_q) begin
            if (LQ == exp_q) begin
              if (pass_q != CNT_MAX) pass_q <= pass_q + CNT_W'(1);
            end else begin
              if (fail_q != CNT_MAX) fail_q <= fail_q + CNT_W'(1);
            end
            cyc_q <= cyc_inc;
            c_q   <= '0;
            if (cyc_inc == ncyc_q) begin
              state_q <= S_FINISH;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_LOW;
              lclk_q  <= 1'b0;
              exp_q   <= ~exp_q;
              if (ld_pos_q == '0) ld_q <= ~exp_q;
            end
          end else begin
            c_q <= c_inc;
            if (c_inc == pert_pos_q) ld_q <= ~exp_q;
          end
        end

        S_FINISH: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign LCLK     = lclk_q;
  assign LD       = ld_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign PASS_CNT = pass_q;
  assign FAIL_CNT = fail_q;

endmodule

// File: tb/tb_dlatn_char_driver.sv
// -----------------------------------------------------------------------------
// tb_dlatn_char_driver
//
// Drives dlatn_char_driver with directed and randomized runs. A small
// stand-in latch (ideal, positive-hold or stuck-at-0) drives LQ from the DUT's
// LCLK/LD. A behavioural model predicts every output per cycle from the run
// parameters: cycle position, phase arithmetic and the alternating expected
// value. One negedge process compares the DUT against that prediction.
// -----------------------------------------------------------------------------
module tb_dlatn_char_driver;

  localparam int CNT_W = 8;
  localparam int PH_W  = 4;

  typedef enum int {L_IDEAL, L_HOLD, L_STUCK0} lmode_e;

  logic             CLK = 1'b0;
  logic             RN = 1'b1;
  logic             START = 1'b0;
  logic [PH_W-1:0]  HALF = '0;
  logic [PH_W-1:0]  SETUP = '0;
  logic [PH_W-1:0]  HOLD = '0;
  logic [CNT_W-1:0] NCYC = '0;
  logic             LQ;
  logic             LCLK;
  logic             LD;
  logic             BUSY;
  logic             DONE;
  logic [CNT_W-1:0] PASS_CNT;
  logic [CNT_W-1:0] FAIL_CNT;

  dlatn_char_driver #(.CNT_W(CNT_W), .PH_W(PH_W)) dut (
    .CLK      (CLK),
    .RN       (RN),
    .START    (START),
    .HALF     (HALF),
    .SETUP    (SETUP),
    .HOLD     (HOLD),
    .NCYC     (NCYC),
    .LQ       (LQ),
    .LCLK     (LCLK),
    .LD       (LD),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .PASS_CNT (PASS_CNT),
    .FAIL_CNT (FAIL_CNT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- latch under test stand-in ----------------
  lmode_e lmode = L_IDEAL;
  logic   lq = 1'b0;
  logic   prev_lclk = 1'b1;
  assign LQ = lq;

  always @(posedge CLK) begin
    #1;
    case (lmode)
      L_IDEAL: if (!LCLK) lq = LD;
      L_HOLD:  if (!LCLK || !prev_lclk) lq = LD;
      default: lq = 1'b0;
    endcase
    prev_lclk = LCLK;
  end

  // ---------------- behavioural model state ----------------
  logic             m_lclk = 1'b1;
  logic             m_ld = 1'b0;
  logic             m_busy = 1'b0;
  logic             m_done = 1'b0;
  logic [CNT_W-1:0] m_pass = '0;
  logic [CNT_W-1:0] m_fail = '0;
  logic             mq = 1'b0;
  logic             m_prev_lclk = 1'b1;
  bit               cmp_en = 1'b0;
  bit               noise_en = 1'b0;
  bit               saw_low;
  logic             closing[$];

  // Model of the latch, driven from the model's own LCLK/LD.
  task automatic latch_tick();
    case (lmode)
      L_IDEAL: if (!m_lclk) mq = m_ld;
      L_HOLD:  if (!m_lclk || !m_prev_lclk) mq = m_ld;
      default: mq = 1'b0;
    endcase
    m_prev_lclk = m_lclk;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      latch_tick();
    end
  endtask

  always @(negedge CLK) begin
    if (cmp_en) begin
      check("LCLK", LCLK, m_lclk);
      check("LD", LD, m_ld);
      check("BUSY", BUSY, m_busy);
      check("DONE", DONE, m_done);
      check("PASS_CNT", PASS_CNT, m_pass);
      check("FAIL_CNT", FAIL_CNT, m_fail);
    end
  end

  // Reset pulse, called mid-cycle; outputs must clear at once.
  task automatic reset_pulse();
    START = 1'b0;
    RN = 1'b0;
    #1;
    check("rst_LCLK", LCLK, 1'b1);
    check("rst_LD", LD, 1'b0);
    check("rst_BUSY", BUSY, 1'b0);
    check("rst_DONE", DONE, 1'b0);
    check("rst_PASS", PASS_CNT, '0);
    check("rst_FAIL", FAIL_CNT, '0);
    m_lclk = 1'b1;
    m_ld   = 1'b0;
    m_busy = 1'b0;
    m_done = 1'b0;
    m_pass = '0;
    m_fail = '0;
    idle(3);
    RN = 1'b1;
  endtask

  // One run: START in the current cycle, then predict cycles 1..2HN+1.
  task automatic run(input int half, input int setup, input int hold, input int ncyc,
                     input int abort_at, output int done_k);
    int h, s, hd, len, j, p, jj;
    logic ld0, e, ej;
    h  = (half < 2) ? 2 : half;
    s  = (setup > h - 1) ? h - 1 : setup;
    hd = (hold > h - 1) ? h - 1 : hold;
    ld0 = m_ld;
    len = 2 * h * ncyc + 1;
    done_k = -1;
    saw_low = 1'b0;
    closing.delete();
    HALF  = PH_W'(half);
    SETUP = PH_W'(setup);
    HOLD  = PH_W'(hold);
    NCYC  = CNT_W'(ncyc);
    START = 1'b1;
    for (int k = 1; k <= len; k++) begin
      next_cycle();
      if (DONE === 1'b1 && done_k < 0) done_k = k;
      if (LCLK === 1'b0) saw_low = 1'b1;
      j = (k - 1) / (2 * h);
      p = (k - 1) % (2 * h);
      if (k < len && p == h - 1) closing.push_back(LD);
      if (k == 1) begin
        m_pass = '0;
        m_fail = '0;
      end
      // Score the latch cycle that ended with the previous CLK cycle.
      if (k > 1 && p == 0) begin
        jj = j - 1;
        ej = ~ld0 ^ jj[0];
        if (mq == ej) begin
          if (m_pass != '1) m_pass = m_pass + 1'b1;
        end else begin
          if (m_fail != '1) m_fail = m_fail + 1'b1;
        end
      end
      if (k == len) begin
        m_done = 1'b1;
        m_busy = 1'b0;
        m_lclk = 1'b1;
      end else begin
        e = ~ld0 ^ j[0];
        m_busy = 1'b1;
        if (p < h) begin
          m_lclk = 1'b0;
          m_ld = (j == 0 && p < h - 1 - s) ? ld0 : e;
        end else begin
          m_lclk = 1'b1;
          m_ld = (p - h >= hd) ? ~e : e;
        end
      end
      latch_tick();
      if (abort_at == k) begin
        reset_pulse();
        return;
      end
      if (noise_en) begin
        START = 1'($urandom_range(0, 1));
        HALF  = PH_W'($urandom);
        SETUP = PH_W'($urandom);
        HOLD  = PH_W'($urandom);
        NCYC  = CNT_W'($urandom);
      end else begin
        START = 1'b0;
      end
    end
    next_cycle();
    START = 1'b0;
    m_done = 1'b0;
    latch_tick();
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dk, h, nc;
    int exp_seq[5] = '{1, 0, 1, 0, 1};
    #1;
    cmp_en = 1'b1;
    reset_pulse();
    idle(4);

    // Nominal run
    lmode = L_IDEAL;
    run(4, 2, 2, 5, 0, dk);
    check("nom_done_lat", dk, 41);
    check("nom_pass", PASS_CNT, 5);
    check("nom_fail", FAIL_CNT, 0);
    check("nom_closing_n", closing.size(), 5);
    for (int i = 0; i < 5 && i < closing.size(); i++)
      check("nom_closing_ld", closing[i], exp_seq[i]);
    idle(2);

    // Clamping
    run(1, 9, 9, 2, 0, dk);
    check("clamp_done_lat", dk, 9);
    check("clamp_pass", PASS_CNT, 2);
    idle(2);

    // Stuck-at-0 latch
    lmode = L_STUCK0;
    run(3, 1, 1, 4, 0, dk);
    check("stuck_pass", PASS_CNT, 2);
    check("stuck_fail", FAIL_CNT, 2);
    idle(2);

    // Positive-hold latch: zero hold fails, one cycle of hold passes
    lmode = L_HOLD;
    run(3, 1, 0, 3, 0, dk);
    check("zero_hold_fails", FAIL_CNT > 0, 1);
    run(3, 1, 1, 3, 0, dk);
    check("one_hold_ok", FAIL_CNT, 0);
    idle(2);

    // Long run with stuck latch, then a rerun clears the counters
    reset_pulse();
    lmode = L_STUCK0;
    run(2, 0, 1, 255, 0, dk);
    check("long_fail", FAIL_CNT, 128);
    check("long_pass", PASS_CNT, 127);
    idle(1);
    run(2, 0, 1, 1, 0, dk);
    check("rerun_fail", FAIL_CNT, 1);
    check("rerun_pass", PASS_CNT, 0);
    idle(2);

    // NCYC = 0
    lmode = L_IDEAL;
    run(4, 1, 1, 0, 0, dk);
    check("ncyc0_done_lat", dk, 1);
    check("ncyc0_lclk_low", saw_low, 0);
    check("ncyc0_pass", PASS_CNT, 0);
    check("ncyc0_fail", FAIL_CNT, 0);
    idle(2);

    // Mid-run abort in latch cycle 3, then a full rerun
    run(3, 1, 1, 10, 2 * 3 * 2 + 2, dk);
    check("abort_no_done", dk, -1);
    idle(2);
    run(3, 1, 1, 10, 0, dk);
    check("after_abort_done_lat", dk, 61);
    check("after_abort_pass", PASS_CNT, 10);
    idle(2);

    // Randomized runs with input noise during the run
    noise_en = 1'b1;
    for (int r = 0; r < 16; r++) begin
      int hf, st, hl;
      lmode = lmode_e'($urandom_range(0, 2));
      idle($urandom_range(0, 3));
      hf = $urandom_range(0, 7);
      st = $urandom_range(0, 15);
      hl = $urandom_range(0, 15);
      nc = $urandom_range(0, 5);
      h  = (hf < 2) ? 2 : hf;
      run(hf, st, hl, nc, 0, dk);
      check("rand_done_lat", dk, 2 * h * nc + 1);
    end
    noise_en = 1'b0;
    idle(3);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
